// File: rtl/accel_wrapper_xform.sv
// Scratchpad-backed accelerator: a bus port loads and inspects a word array, and an
// engine transforms the input half into the output half one word every two cycles.
module accel_wrapper_xform #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 16,
  parameter int LEN_WIDTH  = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [1:0]                mode,
  input  logic [LEN_WIDTH-1:0]      output_length_byte,
  output logic                      done,
  output logic [1:0]                accel_state,
  output logic [2:0]                accel_error,
  input  logic                      mem_en,
  input  logic [ADDR_WIDTH-1:0]     mem_addr,
  input  logic                      mem_we,
  input  logic [DATA_WIDTH/8-1:0]   mem_be,
  input  logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic [DATA_WIDTH-1:0]     mem_rdata
);

  localparam int unsigned BYTES   = DATA_WIDTH / 8;
  localparam int unsigned HALF    = MEM_DEPTH / 2;
  localparam int unsigned MAX_LEN = HALF * BYTES;
  localparam int unsigned IW      = $clog2(MEM_DEPTH);
  localparam int unsigned SHIFT   = $clog2(BYTES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    E_NONE = 3'd0,
    E_BUSY = 3'd1,
    E_ADDR = 3'd2,
    E_LEN  = 3'd3,
    E_MODE = 3'd4
  } err_e;

  state_e                 r_state, w_state_nx;
  err_e                   r_err, w_err_nx;
  logic [1:0]             r_mode;
  logic [LEN_WIDTH-1:0]   r_len;
  logic [IW-1:0]          r_idx, w_idx_nx;
  logic [IW-1:0]          r_last, w_last_nx;
  logic [DATA_WIDTH-1:0]  r_word;
  logic [DATA_WIDTH-1:0]  w_xform;
  logic [BYTES-1:0]       w_eng_be;
  logic [DATA_WIDTH-1:0]  r_mem [MEM_DEPTH];

  logic [ADDR_WIDTH-1:0]  w_widx;
  logic [IW-1:0]          w_bus_idx;
  logic [IW-1:0]          w_wr_idx;
  logic                   w_in_range;
  logic                   w_idle;
  logic                   w_bus_ok;
  logic                   w_bus_err;
  logic                   w_accept;
  logic [31:0]            w_len32;
  logic [31:0]            w_nwords;
  logic [31:0]            w_rem;

  assign w_widx     = mem_addr >> SHIFT;
  assign w_in_range = w_widx < ADDR_WIDTH'(MEM_DEPTH);
  assign w_bus_idx  = w_widx[IW-1:0];
  assign w_idle     = (r_state == S_IDLE);
  assign w_bus_ok   = mem_en && w_idle && w_in_range;
  assign w_bus_err  = mem_en && !(w_idle && w_in_range);
  assign w_accept   = w_idle && start;
  assign w_len32    = 32'(output_length_byte);
  assign w_nwords   = (w_len32 + BYTES - 1) / BYTES;
  assign w_rem      = 32'(r_len) % BYTES;
  assign w_wr_idx   = IW'(HALF) + r_idx;

  assign done        = (r_state == S_DONE);
  assign accel_state = r_state;
  assign accel_error = r_err;

  // Bus error is applied first so that a start-time MODE/LEN error, being later, wins.
  always_comb begin
    w_state_nx = r_state;
    w_err_nx   = r_err;
    w_idx_nx   = r_idx;
    w_last_nx  = r_last;
    if (w_bus_err) begin
      w_err_nx = w_idle ? E_ADDR : E_BUSY;
    end
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (!w_bus_err) begin
            w_err_nx = E_NONE;
          end
          w_idx_nx = '0;
          if (mode == 2'd3) begin
            w_err_nx   = E_MODE;
            w_state_nx = S_DONE;
          end else if (w_len32 > MAX_LEN) begin
            w_err_nx   = E_LEN;
            w_state_nx = S_DONE;
          end else if (w_nwords == 32'd0) begin
            w_state_nx = S_DONE;
          end else begin
            w_last_nx  = IW'(w_nwords - 32'd1);
            w_state_nx = S_READ;
          end
        end
      end
      S_READ:  w_state_nx = S_WRITE;
      S_WRITE: begin
        if (r_idx == r_last) begin
          w_state_nx = S_DONE;
        end else begin
          w_idx_nx   = r_idx + IW'(1);
          w_state_nx = S_READ;
        end
      end
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    w_xform = r_word;
    case (r_mode)
      2'd1: w_xform = ~r_word;
      2'd2: begin
        for (int unsigned b = 0; b < BYTES; b++) begin
          w_xform[8*b +: 8] = r_word[8*(BYTES-1-b) +: 8];
        end
      end
      default: w_xform = r_word;
    endcase
  end

  // Only the final word of a job with a ragged length is partially written.
  always_comb begin
    w_eng_be = '0;
    for (int unsigned b = 0; b < BYTES; b++) begin
      w_eng_be[b] = (r_idx != r_last) || (w_rem == 32'd0) || (b < w_rem);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_err     <= E_NONE;
      r_mode    <= '0;
      r_len     <= '0;
      r_idx     <= '0;
      r_last    <= '0;
      mem_rdata <= '0;
    end else begin
      r_state <= w_state_nx;
      r_err   <= w_err_nx;
      r_idx   <= w_idx_nx;
      r_last  <= w_last_nx;
      if (w_accept) begin
        r_mode <= mode;
        r_len  <= output_length_byte;
      end
      if (mem_en && !mem_we) begin
        mem_rdata <= w_bus_ok ? r_mem[w_bus_idx] : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_bus_ok && mem_we) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (mem_be[b]) begin
          r_mem[w_bus_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
    if (r_state == S_READ) begin
      r_word <= r_mem[r_idx];
    end
    if (r_state == S_WRITE) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (w_eng_be[b]) begin
          r_mem[w_wr_idx][8*b +: 8] <= w_xform[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: doc/accel_wrapper_xform.md
Name: accel_wrapper_xform

Overview:
Parametrised successor to the single-mode accelerator wrapper. It has a local word-organised scratchpad with a byte-enabled bus port. On start, an engine reads the input half of the scratchpad, applies a selectable per-word transform and writes the results to the output half. It then pulses done. It sits between the core-side memory bus and the accelerator register interface. State and error status are exported.

Parameters:
ADDR_WIDTH, 32, bus byte-address width
DATA_WIDTH, 32, word width; multiple of 8, BYTES = DATA_WIDTH/8
MEM_DEPTH, 16, scratchpad words; even, power of two; input region words 0..MEM_DEPTH/2-1, output region MEM_DEPTH/2..MEM_DEPTH-1
LEN_WIDTH, 6, width of output_length_byte

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  level; sampled only in IDLE
mode  in  2  0 copy, 1 bitwise invert, 2 byte-reverse per word, 3 reserved
output_length_byte  in  LEN_WIDTH  bytes to process, sampled with start
done  out  1  one-cycle pulse at job end
accel_state  out  2  0 IDLE, 1 READ, 2 WRITE, 3 DONE
accel_error  out  3  0 NONE, 1 BUSY, 2 ADDR, 3 LEN, 4 MODE
mem_en  in  1  bus access request
mem_addr  in  ADDR_WIDTH  byte address; word index = mem_addr >> log2(BYTES)
mem_we  in  1  1 write, 0 read
mem_be  in  BYTES  byte enables for writes
mem_wdata  in  DATA_WIDTH  write data
mem_rdata  out  DATA_WIDTH  read data, 1-cycle latency

Behaviour:
- Reset (async, any time, including mid-job): state IDLE, done 0, accel_error NONE, mem_rdata 0, counters 0. The scratchpad array is not reset and keeps its contents. A job interrupted by reset is abandoned and no done pulse is issued.
- Bus access in IDLE:
  - Write: updates only bytes with mem_be set, committed at the edge.
  - Read: data appears on mem_rdata the cycle after mem_en & !mem_we.
  - mem_rdata otherwise holds its last value.
- Word index >= MEM_DEPTH: write dropped, read returns 0, accel_error := ADDR.
- Bus access while state != IDLE: write dropped, read returns 0, accel_error := BUSY. The engine is unaffected.
- Start acceptance in IDLE, with start=1:
  - Latch mode and length; clear accel_error, unless a simultaneous bus error sets it in the same edge.
  - mode==3: accel_error := MODE, go to DONE.
  - Else if length > (MEM_DEPTH/2)*BYTES: accel_error := LEN, go to DONE.
  - Else N = ceil(length/BYTES). N==0 goes to DONE; otherwise go to READ with word counter i=0.
- Simultaneous start and bus access in IDLE: the bus access is served first, so the engine sees a write from the same edge.
- READ (1 cycle): read word i of the input region into an internal register. Go to WRITE.
- WRITE (1 cycle): write transform(word) to word MEM_DEPTH/2+i.
  - Byte enables are all ones, except on the last word when length % BYTES != 0; then only the low (length % BYTES) bytes are written and the remaining output bytes are untouched.
  - If i==N-1 go to DONE, else i++ and go to READ.
- DONE (1 cycle): done=1, then IDLE. Latency from the start-sampling edge to done high is 2N+1 edges (1 for N==0 or error).
- Start held high through DONE: a new job is accepted on the first IDLE cycle. Start asserted while busy is ignored and raises no error.
- Byte-reverse: output byte k = input byte BYTES-1-k.
- accel_error is sticky until the next accepted start or reset. A later error overwrites an earlier one.

Test Plan:
- Reset, write 0x11223344 to addr 0x0 with be=4'b1111, read addr 0x0 -> mem_rdata=0x11223344 one cycle later; state 0, done 0 throughout.
- Preload words 0..1 = 0xA1B2C3D4, 0x01020304; mode=2, length=8, start -> done after 5 edges; word 8=0xD4C3B2A1, word 9=0x04030201, error 0.
- Preload word 0 = 0x0000FFFF, word 8 = 0xDEADBEEF; mode=1, length=3 -> word 8=0xDEFF0000, done after 3 edges.
- length=33 (>32 with defaults) -> error 3 and done 1 edge after start, no scratchpad change; then mode=3 -> error 4.
- Write during a running job (length=32) -> write dropped, error 1, job completes after 17 edges; access to addr 0x40 in IDLE -> read returns 0, error 2.
- Assert rst during WRITE of word 2 -> state 0 immediately, no done pulse, words 8..9 keep their results, a new start completes normally.
